// File: rtl/pulse_pkg.sv
// Shared constants and FSM encoding for the pulse period meter family.
package pulse_pkg;

  localparam int PULSE_WIDTH = 26;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// Registers a same-domain signal and flags its rising edge combinationally.
module rising_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic edge_det
);

  logic in_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) in_d <= 1'b0;
    else       in_d <= in;
  end

  assign edge_det = in & ~in_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clock cycles between rising edges of pulse_in, with lock and timeout flags.
module pulse_period_meter
  import pulse_pkg::*;
#(
  parameter int               WIDTH      = PULSE_WIDTH,
  parameter logic [WIDTH-1:0] MAX_PERIOD = 26'h3FF_FFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  state_t           state;
  state_t           state_next;
  logic             edge_det;
  logic [WIDTH-1:0] cnt;
  logic             have_period;
  logic             at_max;

  rising_edge_detect u_edge (
    .clock    (clock),
    .reset    (reset),
    .in       (pulse_in),
    .edge_det (edge_det)
  );

  assign at_max = (cnt == MAX_PERIOD);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (edge_det) state_next = RUN;
      RUN:     if (!edge_det && at_max) state_next = TIMEOUT;
      TIMEOUT: if (edge_det) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    timeout = (state == TIMEOUT);
  end

  // An edge coinciding with cnt == MAX_PERIOD is still a valid measurement.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      have_period  <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (state)
        IDLE, TIMEOUT: begin
          if (edge_det) begin
            cnt         <= WIDTH'(1);
            have_period <= 1'b0;
          end
        end
        RUN: begin
          if (edge_det) begin
            cnt          <= WIDTH'(1);
            period       <= cnt;
            period_valid <= 1'b1;
            locked       <= have_period && (cnt == period);
            have_period  <= 1'b1;
          end else if (at_max) begin
            locked      <= 1'b0;
            have_period <= 1'b0;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
